// File: rtl/nco_clk_gen_if.sv
// Rate-configuration port of the NCO clock-enable generator.
// One ready/valid write of a step value to one channel per cycle.
interface nco_clk_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_step;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_step,
        output cfg_ready
    );
endinterface

// File: rtl/nco_clk_gen.sv
// Multi-channel phase-accumulator clock-enable generator with glitch-free
// run-time rate updates, a common phase-align pulse and a lock indicator.
module nco_clk_gen #(
    parameter int               NUM_CH      = 4,
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] INIT_STEP   = 32'h4000_0000,
    parameter int               LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              sync,
    nco_clk_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] hit;
    logic              sel_pending;
    logic              ready;
    logic              accept;
    logic [CNT_W-1:0]  lock_cnt;
    logic [CNT_W-1:0]  lock_cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(LOCK_CYCLES)) ? v : v + CNT_W'(1);
    endfunction

    // Out-of-range channel numbers match nothing: they look ready and are dropped.
    always_comb begin
        sel_pending = 1'b0;
        hit         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) sel_pending = pending[i];
        end
        ready         = ~sel_pending & ~rst;
        cfg.cfg_ready = ready;
        accept        = cfg.cfg_valid & ready;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = accept && (cfg.cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] acc_p0;
        logic [ACC_W-1:0] step_p0;
        logic [ACC_W-1:0] pend_step_p0;
        logic             pend_q;
        logic             ce_p1;
        logic             oc_p1;
        logic [ACC_W:0]   sum_p0;
        logic             carry;
        logic             step_zero;
        logic             apply;

        assign sum_p0    = {1'b0, acc_p0} + {1'b0, step_p0};
        assign carry     = sum_p0[ACC_W];
        assign step_zero = (step_p0 == '0);
        // New step is taken only at a carry so the current period completes intact.
        assign apply     = pend_q & (carry | step_zero);

        always_ff @(posedge refclk) begin
            if (rst) begin
                acc_p0  <= '0;
                step_p0 <= INIT_STEP;
                pend_q  <= 1'b0;
                ce_p1   <= 1'b0;
                oc_p1   <= 1'b0;
            end else if (sync) begin
                acc_p0 <= '0;
                ce_p1  <= 1'b0;
                oc_p1  <= 1'b0;
                if (pend_q) begin
                    step_p0 <= pend_step_p0;
                    pend_q  <= 1'b0;
                end
                if (hit[g]) begin
                    pend_step_p0 <= cfg.cfg_step;
                    pend_q       <= 1'b1;
                end
            end else begin
                ce_p1 <= carry;
                if (carry) oc_p1 <= ~oc_p1;
                if (apply) begin
                    step_p0 <= pend_step_p0;
                    pend_q  <= 1'b0;
                    acc_p0  <= step_zero ? '0 : sum_p0[ACC_W-1:0];
                end else begin
                    acc_p0  <= sum_p0[ACC_W-1:0];
                end
                if (hit[g]) begin
                    pend_step_p0 <= cfg.cfg_step;
                    pend_q       <= 1'b1;
                end
            end
        end

        assign pending[g] = pend_q;
        assign ce[g]      = ce_p1;
        assign outclk[g]  = oc_p1;
    end

    // Lock stage: any pending update or phase restart re-arms the settle count.
    always_comb begin
        lock_cnt_next = sat_inc(lock_cnt);
        if (sync || (|pending)) lock_cnt_next = '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            locked   <= (lock_cnt_next == CNT_W'(LOCK_CYCLES));
        end
    end
endmodule

// File: tb/tb_nco_clk_gen.sv
// Scoreboard bench for nco_clk_gen: directed scenarios then random traffic,
// checked against an integer-arithmetic reference model.
module tb_nco_clk_gen;
    localparam int NCH  = 4;
    localparam int LOCK = 16;
    localparam int INIT = 'h40;

    typedef struct packed {
        logic [3:0] ce;
        logic [3:0] oc;
        logic       lk;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst;
    logic       sync;
    logic [3:0] ce;
    logic [3:0] outclk;
    logic       locked;

    nco_clk_gen_if #(.NUM_CH(NCH), .ACC_W(8)) cfg ();

    nco_clk_gen #(
        .NUM_CH(NCH), .ACC_W(8), .INIT_STEP(8'h40), .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk(refclk), .rst(rst), .sync(sync), .cfg(cfg),
        .ce(ce), .outclk(outclk), .locked(locked)
    );

    always #5 refclk = ~refclk;

    exp_t out_q[$];
    bit   rdy_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    // Reference model: phase kept as a plain integer, wrapped at 256.
    int         m_acc[NCH];
    int         m_step[NCH];
    int         m_pstep[NCH];
    bit         m_pend[NCH];
    logic [3:0] m_ce = '0;
    logic [3:0] m_oc = '0;
    int         m_cnt = 0;
    bit         m_locked = 0;

    task automatic model_edge(input bit r, input bit s, input bit take, input int ch, input int st);
        bit any_pend;
        int nacc;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_step[i] = INIT; m_pend[i] = 0;
            end
            m_ce = '0; m_oc = '0; m_cnt = 0; m_locked = 0;
            return;
        end
        any_pend = 0;
        for (int i = 0; i < NCH; i++) any_pend |= m_pend[i];
        for (int i = 0; i < NCH; i++) begin
            if (s) begin
                m_acc[i] = 0; m_ce[i] = 0; m_oc[i] = 0;
                if (m_pend[i]) begin m_step[i] = m_pstep[i]; m_pend[i] = 0; end
            end else begin
                nacc = m_acc[i] + m_step[i];
                m_ce[i] = (nacc >= 256);
                if (nacc >= 256) begin
                    m_oc[i] = ~m_oc[i];
                    nacc -= 256;
                end
                if (m_pend[i] && (m_ce[i] || m_step[i] == 0)) begin
                    if (m_step[i] == 0) nacc = 0;
                    m_step[i] = m_pstep[i];
                    m_pend[i] = 0;
                end
                m_acc[i] = nacc;
            end
        end
        if (take) begin m_pstep[ch] = st; m_pend[ch] = 1; end
        if (s || any_pend) m_cnt = 0;
        else if (m_cnt < LOCK) m_cnt++;
        m_locked = (m_cnt == LOCK);
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input int ch, input int st);
        bit   rdy;
        exp_t e;
        @(negedge refclk);
        rst           = r;
        sync          = s;
        cfg.cfg_valid = v;
        cfg.cfg_ch    = ch[1:0];
        cfg.cfg_step  = st[7:0];
        rdy = !r && !m_pend[ch];
        rdy_q.push_back(rdy);
        model_edge(r, s, v && rdy, ch, st);
        e.ce = m_ce; e.oc = m_oc; e.lk = m_locked;
        out_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int st);
        cyc(0, 0, 1, ch, st);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_n, act, exp);
        end
    endtask

    // Output monitor, just after the active edge.
    always @(posedge refclk) begin
        #1;
        if (out_q.size() > 0) begin
            exp_t e;
            e = out_q.pop_front();
            cyc_n++;
            check("ce", ce, e.ce);
            check("outclk", outclk, e.oc);
            check("locked", {3'b0, locked}, {3'b0, e.lk});
        end
    end

    // cfg_ready monitor, after the inputs settle mid-cycle.
    always @(negedge refclk) begin
        #2;
        if (rdy_q.size() > 0) begin
            bit r;
            r = rdy_q.pop_front();
            check("cfg_ready", {3'b0, cfg.cfg_ready}, {3'b0, r});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, s, v, st;
        rst = 1'b1; sync = 1'b0;
        cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_step = '0;
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0; m_step[i] = INIT; m_pstep[i] = 0; m_pend[i] = 0;
        end

        repeat (3) cyc(1, 0, 0, 0, 0);
        idle(20);
        wr(1, 'h80);            idle(24);
        wr(2, 'h00);            idle(6);
        wr(2, 'h10);            idle(40);
        wr(1, 'h20);
        wr(1, 'h40);
        wr(3, 'h30);            idle(20);
        wr(1, 'h80);            idle(10);
        wr(2, 'h30);            idle(10);
        wr(3, 'h40);            idle(10);
        cyc(0, 1, 0, 0, 0);     idle(24);
        wr(0, 'hFF);
        cyc(1, 0, 0, 0, 0);     idle(24);
        cyc(0, 1, 1, 2, 'h55);  idle(20);

        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom % 1000) < 3;
            s  = ($urandom % 100) < 2;
            v  = ($urandom % 100) < 40;
            st = (($urandom % 6) == 0) ? 0 : int'($urandom % 256);
            cyc(r[0], s[0], v[0], int'($urandom % NCH), st);
        end
        idle(2);
        repeat (3) @(posedge refclk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
